// File: rtl/front_panel_pkg.sv
// Shared types and LED mode decode for the front-panel controller.
package front_panel_pkg;

    typedef enum logic [1:0] {
        LED_OFF    = 2'b00,
        LED_STEADY = 2'b01,
        LED_BLINK  = 2'b10,
        LED_FAULT  = 2'b11
    } ledMode_t;

    // Returns {R,G,B} lit flags for one LED, before pin polarity is applied.
    function automatic logic [2:0] led_gate(input ledMode_t mode, input logic phase,
                                            input logic [2:0] pwm_on);
        logic [2:0] lit;
        lit = 3'b000;
        case (mode)
            LED_OFF:    lit = 3'b000;
            LED_STEADY: lit = pwm_on;
            LED_BLINK:  lit = phase ? pwm_on : 3'b000;
            LED_FAULT:  lit = {phase, 2'b00};
            default:    lit = 3'b000;
        endcase
        return lit;
    endfunction

endpackage

// File: rtl/front_panel_debounce.sv
// One push button: 2-flop synchroniser, agreement counter, debounced level and press pulse.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sample;
    logic [CW-1:0] cnt;

    // cnt only runs while sample disagrees with level and is cleared at CNT_LAST, so it never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            sample <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync1  <= pin ^ ACTIVE_LOW;
            sample <= sync1;
            press  <= 1'b0;
            if (sample == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sample;
                press <= sample;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/front_panel.sv
// Front-panel controller: debounced buttons plus PWM/blink/fault RGB LED drive with registered pins.
module front_panel
    import front_panel_pkg::*;
#(
    parameter int NBUTTONS          = 2,
    parameter int NLEDS             = 2,
    parameter int DEBOUNCE_CYCLES   = 65536,
    parameter int PWM_BITS          = 8,
    parameter int BLINK_BITS        = 24,
    parameter bit BUTTON_ACTIVE_LOW = 1'b0,
    parameter bit LED_ACTIVE_LOW    = 1'b1,
    parameter int FAULT_LED         = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NBUTTONS-1:0]            buttonIn,
    output logic [NBUTTONS-1:0]            buttonLevel,
    output logic [NBUTTONS-1:0]            buttonPress,
    input  logic [2*NLEDS-1:0]             ledMode,
    input  logic [3*PWM_BITS*NLEDS-1:0]    ledDuty,
    input  logic                           faultIn,
    output logic [NLEDS-1:0]               ledR,
    output logic [NLEDS-1:0]               ledG,
    output logic [NLEDS-1:0]               ledB
);

    localparam int DUTY_W = 3 * PWM_BITS;

    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic                  phase;

    for (genvar i = 0; i < NBUTTONS; i++) begin : g_button
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (BUTTON_ACTIVE_LOW)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .pin   (buttonIn[i]),
            .level (buttonLevel[i]),
            .press (buttonPress[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt   <= '0;
            blink_cnt <= '0;
        end else begin
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
            blink_cnt <= blink_cnt + BLINK_BITS'(1);
        end
    end

    assign phase = blink_cnt[BLINK_BITS-1];

    for (genvar i = 0; i < NLEDS; i++) begin : g_led
        logic [PWM_BITS-1:0] duty_r;
        logic [PWM_BITS-1:0] duty_g;
        logic [PWM_BITS-1:0] duty_b;
        logic [2:0]          pwm_on;
        ledMode_t            mode;
        logic [2:0]          pin_q;

        assign duty_r = ledDuty[DUTY_W*i + 2*PWM_BITS +: PWM_BITS];
        assign duty_g = ledDuty[DUTY_W*i +   PWM_BITS +: PWM_BITS];
        assign duty_b = ledDuty[DUTY_W*i             +: PWM_BITS];

        // All-ones duty is forced on; a plain compare would leave one dark slot per period.
        assign pwm_on[2] = (duty_r == '1) || (pwm_cnt < duty_r);
        assign pwm_on[1] = (duty_g == '1) || (pwm_cnt < duty_g);
        assign pwm_on[0] = (duty_b == '1) || (pwm_cnt < duty_b);

        assign mode = (faultIn && (i == FAULT_LED)) ? LED_FAULT : ledMode_t'(ledMode[2*i +: 2]);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pin_q <= {3{LED_ACTIVE_LOW}};
            end else begin
                pin_q <= led_gate(mode, phase, pwm_on) ^ {3{LED_ACTIVE_LOW}};
            end
        end

        assign ledR[i] = pin_q[2];
        assign ledG[i] = pin_q[1];
        assign ledB[i] = pin_q[0];
    end

endmodule
